// File: rtl/vec_register_file_pkg.sv
// Shared types and defaults for the vector register file.
// One vector is four independent lanes.
package vec_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_NUM_REGS   = 8;
    localparam int unsigned DEFAULT_SEL_W      = $clog2(DEFAULT_NUM_REGS);
    localparam int unsigned VEC_LANES          = 4;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] lane_t;
    typedef lane_t [VEC_LANES-1:0] vec_t;
    typedef logic [DEFAULT_SEL_W-1:0] reg_sel_t;

endpackage

// File: rtl/vec_register_file_read_port.sv
// Combinational NUM_REGS-to-1 vector multiplexer.
// It is used for each read port of the register file.
module vec_read_port
    import vec_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned NUM_REGS   = DEFAULT_NUM_REGS,
    localparam int unsigned SEL_W     = $clog2(NUM_REGS)
) (
    input  logic [NUM_REGS-1:0][VEC_LANES-1:0][DATA_WIDTH-1:0] regs_i,
    input  logic [SEL_W-1:0]                                   sel_i,
    output logic [VEC_LANES-1:0][DATA_WIDTH-1:0]               data_o
);

    // NUM_REGS is a power of two, so every select value is in range.
    always_comb begin
        data_o = regs_i[sel_i];
    end

endmodule

// File: rtl/vec_register_file.sv
// Vector register file: two combinational read ports, one synchronous write port.
// There is no write-through bypass; written data appears after the capturing edge.
module vec_register_file
    import vec_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned NUM_REGS   = DEFAULT_NUM_REGS,
    localparam int unsigned SEL_W     = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  regWrEn,
    input  logic [SEL_W-1:0]      rSel1,
    input  logic [SEL_W-1:0]      rSel2,
    input  logic [SEL_W-1:0]      regToWrite,
    input  logic [DATA_WIDTH-1:0] regWriteData_0,
    input  logic [DATA_WIDTH-1:0] regWriteData_1,
    input  logic [DATA_WIDTH-1:0] regWriteData_2,
    input  logic [DATA_WIDTH-1:0] regWriteData_3,
    output logic [DATA_WIDTH-1:0] reg1Out_0,
    output logic [DATA_WIDTH-1:0] reg1Out_1,
    output logic [DATA_WIDTH-1:0] reg1Out_2,
    output logic [DATA_WIDTH-1:0] reg1Out_3,
    output logic [DATA_WIDTH-1:0] reg2Out_0,
    output logic [DATA_WIDTH-1:0] reg2Out_1,
    output logic [DATA_WIDTH-1:0] reg2Out_2,
    output logic [DATA_WIDTH-1:0] reg2Out_3
);

    logic [NUM_REGS-1:0][VEC_LANES-1:0][DATA_WIDTH-1:0] regs_d, regs_q;
    logic [VEC_LANES-1:0][DATA_WIDTH-1:0]               wr_vec;
    logic [VEC_LANES-1:0][DATA_WIDTH-1:0]               rd1_vec, rd2_vec;

    always_comb begin
        wr_vec[0] = regWriteData_0;
        wr_vec[1] = regWriteData_1;
        wr_vec[2] = regWriteData_2;
        wr_vec[3] = regWriteData_3;
    end

    always_comb begin
        regs_d = regs_q;
        if (regWrEn) begin
            regs_d[regToWrite] = wr_vec;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    vec_read_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_REGS  (NUM_REGS)
    ) u_read_port1 (
        .regs_i(regs_q),
        .sel_i (rSel1),
        .data_o(rd1_vec)
    );

    vec_read_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_REGS  (NUM_REGS)
    ) u_read_port2 (
        .regs_i(regs_q),
        .sel_i (rSel2),
        .data_o(rd2_vec)
    );

    always_comb begin
        reg1Out_0 = rd1_vec[0];
        reg1Out_1 = rd1_vec[1];
        reg1Out_2 = rd1_vec[2];
        reg1Out_3 = rd1_vec[3];
        reg2Out_0 = rd2_vec[0];
        reg2Out_1 = rd2_vec[1];
        reg2Out_2 = rd2_vec[2];
        reg2Out_3 = rd2_vec[3];
    end

endmodule

// File: tb/tb_vec_register_file.sv
// Directed bench for vec_register_file: expected read-port values are queued
// when stimulus is applied and popped when the outputs are sampled.
module tb_vec_register_file;

    logic       clk;
    logic       reset;
    logic       regWrEn;
    logic [2:0] rSel1, rSel2, regToWrite;
    logic [7:0] wd0, wd1, wd2, wd3;
    logic [7:0] o1_0, o1_1, o1_2, o1_3;
    logic [7:0] o2_0, o2_1, o2_2, o2_3;

    typedef struct {
        string       tag;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    vec_register_file dut (
        .clk           (clk),
        .reset         (reset),
        .regWrEn       (regWrEn),
        .rSel1         (rSel1),
        .rSel2         (rSel2),
        .regToWrite    (regToWrite),
        .regWriteData_0(wd0),
        .regWriteData_1(wd1),
        .regWriteData_2(wd2),
        .regWriteData_3(wd3),
        .reg1Out_0     (o1_0),
        .reg1Out_1     (o1_1),
        .reg1Out_2     (o1_2),
        .reg1Out_3     (o1_3),
        .reg2Out_0     (o2_0),
        .reg2Out_1     (o2_1),
        .reg2Out_2     (o2_2),
        .reg2Out_3     (o2_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane 0 is the most significant byte so constants read like the test plan.
    function automatic logic [31:0] vec(input logic [7:0] l0, l1, l2, l3);
        return {l0, l1, l2, l3};
    endfunction

    task automatic push(input string tag, input logic [31:0] e1, input logic [31:0] e2);
        exp_t e;
        e.tag = tag;
        e.e1  = e1;
        e.e2  = e2;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t        e;
        logic [31:0] obs1, obs2;
        obs1 = vec(o1_0, o1_1, o1_2, o1_3);
        obs2 = vec(o2_0, o2_1, o2_2, o2_3);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty observed=%h/%h expected=entry", obs1, obs2);
            return;
        end
        e = sb.pop_front();
        checks++;
        assert (obs1 === e.e1) else begin
            errors++;
            $error("FAIL %s port1 observed=%h expected=%h", e.tag, obs1, e.e1);
        end
        checks++;
        assert (obs2 === e.e2) else begin
            errors++;
            $error("FAIL %s port2 observed=%h expected=%h", e.tag, obs2, e.e2);
        end
    endtask

    task automatic set_data(input logic [31:0] v);
        {wd0, wd1, wd2, wd3} = v;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] V_DEAD = 32'hDEADBEEF;
    localparam logic [31:0] V_1A   = 32'h1A2B3C4D;
    localparam logic [31:0] V_55   = 32'h55555555;

    initial begin
        reset      = 1'b1;
        regWrEn    = 1'b0;
        rSel1      = 3'd0;
        rSel2      = 3'd0;
        regToWrite = 3'd0;
        set_data(32'h0);
        #12;
        push("reset_active", 32'h0, 32'h0);
        check_out();
        reset = 1'b0;
        #1;
        push("reset_released", 32'h0, 32'h0);
        check_out();
        for (int i = 0; i < 8; i++) begin
            rSel1 = i[2:0];
            rSel2 = 3'(7 - i);
            #1;
            push("reset_all_regs", 32'h0, 32'h0);
            check_out();
        end

        // Write register 1; before the edge the old (zero) contents are read.
        @(negedge clk);
        regWrEn    = 1'b1;
        regToWrite = 3'd1;
        set_data(V_DEAD);
        rSel1 = 3'd1;
        rSel2 = 3'd0;
        #1;
        push("wr1_pre_edge", 32'h0, 32'h0);
        check_out();
        push("wr1", V_DEAD, 32'h0);
        edge_step();
        check_out();

        regToWrite = 3'd7;
        set_data(V_1A);
        rSel1 = 3'd7;
        push("wr7", V_1A, 32'h0);
        edge_step();
        check_out();

        // Dual read, no clock edge between select change and sample.
        regWrEn = 1'b0;
        rSel1   = 3'd1;
        rSel2   = 3'd7;
        #1;
        push("dual_read", V_DEAD, V_1A);
        check_out();

        regToWrite = 3'd1;
        set_data(V_55);
        push("wren_low", V_DEAD, V_1A);
        edge_step();
        check_out();

        @(negedge clk);
        regWrEn = 1'b1;
        rSel2   = 3'd1;
        #1;
        push("no_bypass_pre", V_DEAD, V_DEAD);
        check_out();
        push("no_bypass_post", V_55, V_55);
        edge_step();
        check_out();

        // Back-to-back writes of the same register: last value wins.
        regToWrite = 3'd2;
        set_data(32'h11111111);
        rSel1 = 3'd2;
        rSel2 = 3'd2;
        edge_step();
        set_data(32'h22222222);
        push("repeat_write", 32'h22222222, 32'h22222222);
        edge_step();
        check_out();

        regToWrite = 3'd0;
        set_data(32'h0F1E2D3C);
        rSel1 = 3'd0;
        rSel2 = 3'd7;
        push("reg0_writable", 32'h0F1E2D3C, V_1A);
        edge_step();
        check_out();

        // Asynchronous reset between edges, with a write held during reset.
        regWrEn = 1'b0;
        rSel1   = 3'd1;
        rSel2   = 3'd7;
        #1;
        push("pre_async_reset", V_55, V_1A);
        check_out();
        #1;
        reset      = 1'b1;
        regWrEn    = 1'b1;
        regToWrite = 3'd3;
        set_data(32'hAAAAAAAA);
        #1;
        push("async_reset", 32'h0, 32'h0);
        check_out();
        edge_step();
        @(negedge clk);
        reset   = 1'b0;
        regWrEn = 1'b0;
        rSel1   = 3'd3;
        rSel2   = 3'd0;
        #1;
        push("write_during_reset", 32'h0, 32'h0);
        check_out();

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
